// File: rtl/ttni_source_fsm.sv
// TTNI source packetiser: reads a message from the outbound buffer and emits
// HEAD, port-id, time-stamp and payload flits on VC0 with valid/ready.
`timescale 1ns/1ps
module ttni_source_fsm #(
    parameter int VCHANNELS       = 1,
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
    parameter int ADDR_WIDTH      = 11,
    parameter int BASE_ADDR       = 40,
    parameter int MAX_PAYLOAD     = 1024
) (
    input  logic                  clk,
    input  logic                  rst_source,
    input  logic                  start,
    input  logic [15:0]           msg_len,
    input  logic [4:0]            dest_id,
    input  logic [4:0]            src_portid,
    input  logic [63:0]           GTB,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [31:0]           rd_data,
    output logic [FLIT_WIDTH-1:0] flit,
    output logic [VCHANNELS-1:0]  valid,
    input  logic [VCHANNELS-1:0]  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           tx_count
);

    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HEAD  = 3'd1;
    localparam logic [2:0] S_PORT  = 3'd2;
    localparam logic [2:0] S_STAMP = 3'd3;
    localparam logic [2:0] S_RD    = 3'd4;
    localparam logic [2:0] S_PAY   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [FLIT_TYPE_WIDTH-1:0] T_BODY = FLIT_TYPE_WIDTH'(0);
    localparam logic [FLIT_TYPE_WIDTH-1:0] T_HEAD = FLIT_TYPE_WIDTH'(1);
    localparam logic [FLIT_TYPE_WIDTH-1:0] T_LAST = FLIT_TYPE_WIDTH'(2);

    logic [2:0]                 state;
    logic [LEN_W-1:0]           idx_q;
    logic [LEN_W-1:0]           len_q;
    logic [4:0]                 port_q;
    logic [FLIT_WIDTH-1:0]      flit_q;
    logic [FLIT_DATA_WIDTH-1:0] pay_q;
    logic                       pay_first;
    logic                       pay_last;
    logic                       valid_q;
    logic                       xfer;
    logic                       unused_inputs;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [15:0] n);
        if ({16'd0, n} > 32'(MAX_PAYLOAD))
            return LEN_W'(MAX_PAYLOAD);
        return LEN_W'(n);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [LEN_W-1:0] i);
        return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(i);
    endfunction

    assign xfer          = valid_q & ready[0];
    assign valid         = VCHANNELS'(valid_q);
    assign unused_inputs = &{1'b0, GTB[63:32], ready};

    // Payload data comes straight from the buffer on the first PAY cycle and
    // from the holding register while the flit is stalled afterwards.
    assign flit = (state == S_PAY)
                ? {(pay_last ? T_LAST : T_BODY), (pay_first ? FLIT_DATA_WIDTH'(rd_data) : pay_q)}
                : flit_q;

    always_ff @(posedge clk or posedge rst_source) begin
        if (rst_source) begin
            state     <= S_IDLE;
            idx_q     <= '0;
            flit_q    <= '0;
            valid_q   <= 1'b0;
            pay_first <= 1'b0;
            pay_last  <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            tx_count  <= '0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (msg_len == 16'd0) begin
                            err <= 1'b1;
                        end else begin
                            state   <= S_HEAD;
                            busy    <= 1'b1;
                            valid_q <= 1'b1;
                            idx_q   <= '0;
                            flit_q  <= {T_HEAD, FLIT_DATA_WIDTH'(dest_id)};
                        end
                    end
                end
                S_HEAD: begin
                    if (xfer) begin
                        state  <= S_PORT;
                        flit_q <= {T_BODY, FLIT_DATA_WIDTH'(port_q)};
                    end
                end
                S_PORT: begin
                    // Stamp is taken once here and held through any stall.
                    if (xfer) begin
                        state  <= S_STAMP;
                        flit_q <= {T_BODY, FLIT_DATA_WIDTH'(GTB[31:0])};
                    end
                end
                S_STAMP: begin
                    if (xfer) begin
                        state   <= S_RD;
                        valid_q <= 1'b0;
                        flit_q  <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= addr_of(idx_q);
                    end
                end
                S_RD: begin
                    state     <= S_PAY;
                    valid_q   <= 1'b1;
                    pay_first <= 1'b1;
                    pay_last  <= (idx_q == len_q - LEN_W'(1));
                end
                S_PAY: begin
                    pay_first <= 1'b0;
                    if (xfer) begin
                        valid_q <= 1'b0;
                        if (pay_last) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            tx_count <= tx_count + 32'd1;
                        end else begin
                            state   <= S_RD;
                            idx_q   <= idx_q + LEN_W'(1);
                            rd_en   <= 1'b1;
                            rd_addr <= addr_of(idx_q + LEN_W'(1));
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            len_q  <= clamp_len(msg_len);
            port_q <= src_portid;
        end
        if (pay_first)
            pay_q <= FLIT_DATA_WIDTH'(rd_data);
    end

endmodule

// File: tb/tb_ttni_source_fsm.sv
// Bench for ttni_source_fsm: table of packet vectors plus hand-written stall,
// mid-packet reset and ignored-start sequences, with a flit scoreboard.
`timescale 1ns/1ps
module tb_ttni_source_fsm;

    localparam int BASE = 40;

    logic        clk = 1'b0;
    logic        rst_source = 1'b1;
    logic        start = 1'b0;
    logic [15:0] msg_len = '0;
    logic [4:0]  dest_id = '0;
    logic [4:0]  src_portid = '0;
    logic [63:0] GTB = '0;
    logic [31:0] rd_data = '0;
    logic [0:0]  ready = 1'b1;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [33:0] flit;
    logic [0:0]  valid;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] tx_count;

    ttni_source_fsm dut (
        .clk(clk), .rst_source(rst_source), .start(start), .msg_len(msg_len),
        .dest_id(dest_id), .src_portid(src_portid), .GTB(GTB),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .flit(flit), .valid(valid), .ready(ready),
        .busy(busy), .done(done), .err(err), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] len;
        logic [4:0]  dest;
        logic [4:0]  port;
        logic [31:0] gtb;
        bit          rnd_ready;
        bit          exp_err;
        int          exp_npay;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] mem[2048];
    logic [33:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          xfers = 0;
    int          n_done = 0;
    int          n_err = 0;
    int          pkt_id = 0;
    int          seen_pkt = 0;
    int          exp_addr = BASE;
    logic [10:0] last_rd_addr = '0;
    bit          prev_stall = 1'b0;
    logic [33:0] prev_flit = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_packet(input int npay, input logic [4:0] d, input logic [4:0] p,
                               input logic [31:0] st);
        exp_q.push_back({2'b01, 27'd0, d});
        exp_q.push_back({2'b00, 27'd0, p});
        exp_q.push_back({2'b00, st});
        for (int i = 0; i < npay; i++)
            exp_q.push_back({(i == npay - 1) ? 2'b10 : 2'b00, mem[BASE + i]});
    endtask

    task automatic run_until_done(input int d0, input bit rnd);
        for (int c = 0; c < 8000 && n_done == d0; c++) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        ready = 1'b1;
        check("done_pulses", 64'(n_done - d0), 64'd1);
    endtask

    // Buffer model: data is valid only in the cycle after rd_en.
    initial forever begin
        @(posedge clk);
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= $urandom;
    end

    // Monitor: outputs are sampled on the falling edge; a valid&ready seen here
    // transfers on the following rising edge.
    initial forever begin
        @(negedge clk);
        if (rst_source) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(valid[0]), 64'd1);
                check("stall_flit", 64'(flit), 64'(prev_flit));
            end
            if (pkt_id != seen_pkt) begin
                seen_pkt = pkt_id;
                exp_addr = BASE;
            end
            if (rd_en) begin
                check("rd_addr", 64'(rd_addr), 64'(exp_addr));
                exp_addr++;
                last_rd_addr = rd_addr;
            end
            if (done) n_done++;
            if (err)  n_err++;
            if (valid[0] && ready[0]) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL flit_unexpected actual=%0h required=none", flit);
                end else begin
                    check("flit", 64'(flit), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = valid[0] && !ready[0];
            prev_flit  = flit;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int   d0, e0, x0, xs;
        logic [31:0] tx0;
        bit   found;
        vec_t v;

        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        vecs[0] = '{16'd4,    5'd3,  5'h0A, 32'h0000_1234, 1'b0, 1'b0, 4};
        vecs[1] = '{16'd0,    5'd2,  5'd1,  32'h0000_0055, 1'b0, 1'b1, 0};
        vecs[2] = '{16'd1,    5'd31, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0, 1};
        vecs[3] = '{16'd6,    5'd17, 5'd4,  32'hDEAD_BEEF, 1'b1, 1'b0, 6};
        vecs[4] = '{16'd2000, 5'd9,  5'd12, 32'h0BAD_F00D, 1'b0, 1'b0, 1024};
        vecs[5] = '{16'd3,    5'd1,  5'd30, 32'h8000_0001, 1'b1, 1'b0, 3};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_flit", 64'(flit), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_tx_count", 64'(tx_count), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        rst_source = 1'b0;
        tick();

        // Reset during the third payload flit of an 8-word message
        d0 = n_done; x0 = xfers;
        msg_len = 16'd8; dest_id = 5'd2; src_portid = 5'd3; GTB = 64'h1_0000_4444;
        start = 1'b1; pkt_id++;
        push_packet(8, 5'd2, 5'd3, 32'h0000_4444);
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (xfers == x0 + 5 && valid[0]) found = 1'b1;
        end
        check("mid_rst_reached_pay2", 64'(found), 64'd1);
        rst_source = 1'b1;
        #1;
        check("mid_rst_valid_drop", 64'(valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        tick(); tick();
        check("mid_rst_no_done", 64'(n_done), 64'(d0));
        check("mid_rst_tx_count", 64'(tx_count), 64'd0);
        rst_source = 1'b0;
        tick();

        // Vector table
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            tx0 = tx_count; d0 = n_done; e0 = n_err;
            msg_len = v.len; dest_id = v.dest; src_portid = v.port;
            GTB = {32'hA5A5_A5A5, v.gtb};
            ready = 1'b1;
            start = 1'b1; pkt_id++;
            if (v.exp_npay > 0) push_packet(v.exp_npay, v.dest, v.port, v.gtb);
            tick();
            start = 1'b0;
            check("vec_valid_after_start", 64'(valid[0]), 64'(v.exp_npay > 0));
            check("vec_err", 64'(err), 64'(v.exp_err));
            check("vec_busy", 64'(busy), 64'(v.exp_npay > 0));
            if (v.exp_err) begin
                tick();
                check("err_one_cycle", 64'(err), 64'd0);
                tick();
                check("err_valid", 64'(valid), 64'd0);
                check("err_busy", 64'(busy), 64'd0);
                check("err_pulses", 64'(n_err - e0), 64'd1);
                check("err_tx_count", 64'(tx_count), 64'(tx0));
            end else begin
                run_until_done(d0, v.rnd_ready);
                check("vec_all_flits", 64'(exp_q.size()), 64'd0);
                check("vec_tx_count", 64'(tx_count), 64'(tx0 + 32'd1));
                check("vec_busy_end", 64'(busy), 64'd0);
                if (v.len == 16'd2000)
                    check("clamp_last_rd_addr", 64'(last_rd_addr), 64'd1063);
            end
            tick();
        end

        // Stall on the time-stamp flit while GTB keeps moving
        tx0 = tx_count; d0 = n_done; x0 = xfers;
        msg_len = 16'd2; dest_id = 5'd5; src_portid = 5'd6; GTB = 64'h0000_1234;
        start = 1'b1; pkt_id++;
        push_packet(2, 5'd5, 5'd6, 32'h0000_1234);
        tick();
        start = 1'b0;
        for (int c = 0; c < 20 && xfers < x0 + 2; c++) tick();
        check("stamp_reached", 64'(xfers - x0), 64'd2);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stamp_hold_flit", 64'(flit), 64'h0_0000_1234);
            check("stamp_hold_valid", 64'(valid), 64'd1);
            GTB = GTB + 64'd1;
            tick();
        end
        ready = 1'b1;
        xs = xfers;
        tick();
        check("stamp_xfer_first_ready", 64'(xfers - xs), 64'd1);
        run_until_done(d0, 1'b0);
        check("stall_tx_count", 64'(tx_count), 64'(tx0 + 32'd1));
        tick();

        // start pulses mid-packet and during DONE are ignored
        tx0 = tx_count; d0 = n_done;
        msg_len = 16'd3; dest_id = 5'd7; src_portid = 5'd9; GTB = 64'h77;
        start = 1'b1; pkt_id++;
        push_packet(3, 5'd7, 5'd9, 32'h77);
        tick();
        start = 1'b0; msg_len = 16'd5; dest_id = 5'd1; src_portid = 5'd2;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            tick();
            if (done) found = 1'b1;
        end
        check("ignore_done_seen", 64'(found), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("ignore_done_pulses", 64'(n_done - d0), 64'd1);
        check("ignore_tx_count", 64'(tx_count), 64'(tx0 + 32'd1));
        check("ignore_valid_idle", 64'(valid), 64'd0);
        check("ignore_busy_idle", 64'(busy), 64'd0);
        check("ignore_all_flits", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
